dispatch_s: RTL



---
 rtl/datapath_pkg.sv | 46 ++++
 rtl/dispatch_s_if.sv | 37 +++
 rtl/dispatch_hazard.sv | 59 +++++
 rtl/dispatch_s.sv | 126 ++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types: RST status entries, dispatch FSM state, dispatch holding
// entry and FU tag constants.
package datapath_pkg;

  localparam int DS_NREGS = 32;
  localparam int DS_NFU   = 4;
  localparam int SEL_W    = $clog2(DS_NREGS);
  localparam int TAG_W    = $clog2(DS_NFU);

  localparam logic [TAG_W-1:0] FU_ALU = 2'd0;
  localparam logic [TAG_W-1:0] FU_MUL = 2'd1;
  localparam logic [TAG_W-1:0] FU_LS  = 2'd2;
  localparam logic [TAG_W-1:0] FU_TC  = 2'd3;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SPEC   = 2'd1,
    FLUSH  = 2'd2
  } dispatch_state_t;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic             spec;
  } rst_entry_t;

  typedef rst_entry_t [DS_NREGS-1:0] rst_s_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] fu;
    logic [SEL_W-1:0] rd;
    logic             rd_we;
    logic [SEL_W-1:0] rs1;
    logic [SEL_W-1:0] rs2;
    logic             br;
  } dispatch_entry_t;

  function automatic logic [DS_NFU-1:0] fu_onehot(input logic [TAG_W-1:0] fu);
    logic [DS_NFU-1:0] r;
    r     = '0;
    r[fu] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dispatch_s_if.sv
// Bundle of the dispatch_s ports for integration; DS is the dispatch-side view.
interface dispatch_s_if;
  import datapath_pkg::*;

  logic                CLK;
  logic                RST;
  logic                in_valid;
  logic                in_ready;
  logic [TAG_W-1:0]    in_fu;
  logic [SEL_W-1:0]    in_rd;
  logic                in_rd_we;
  logic [SEL_W-1:0]    in_rs1;
  logic [SEL_W-1:0]    in_rs2;
  logic                in_br;
  rst_s_t              status;
  logic [SEL_W-1:0]    wb_sel;
  logic                wb_write;
  logic [DS_NFU-1:0]   fu_ready;
  logic [DS_NFU-1:0]   fu_valid;
  logic                op_rs1_wait;
  logic                op_rs2_wait;
  logic [TAG_W-1:0]    op_rs1_tag;
  logic [TAG_W-1:0]    op_rs2_tag;
  logic [SEL_W-1:0]    di_sel;
  logic                di_write;
  logic [TAG_W-1:0]    di_tag;
  logic                spec;
  logic                flush;
  logic                resolved;

  modport DS (
    input  CLK, RST, in_valid, in_fu, in_rd, in_rd_we, in_rs1, in_rs2, in_br,
           status, wb_sel, wb_write, fu_ready, flush, resolved,
    output in_ready, fu_valid, op_rs1_wait, op_rs2_wait, op_rs1_tag, op_rs2_tag,
           di_sel, di_write, di_tag, spec
  );
endinterface

// File: rtl/dispatch_hazard.sv
// Combinational hazard lookup: WAW, FU availability and per-operand wait/tag.
// Optional writeback bypass of operand wait under DISPATCH_WB_BYPASS_EN.
module dispatch_hazard
  import datapath_pkg::*;
(
  input  logic [TAG_W-1:0]  fu,
  input  logic [SEL_W-1:0]  rd,
  input  logic              rd_we,
  input  logic [SEL_W-1:0]  rs1,
  input  logic [SEL_W-1:0]  rs2,
  input  rst_s_t            status,
  input  logic [DS_NFU-1:0] fu_ready,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic              wb_write,
  output logic              waw,
  output logic              fu_free,
  output logic              rs1_wait,
  output logic              rs2_wait,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [TAG_W-1:0]  rs2_tag
);

  logic [SEL_W-1:0] rs     [2];
  logic [1:0]       wait_v;
  logic [TAG_W-1:0] tag_v  [2];
  logic             unused_status;

  assign rs[0] = rs1;
  assign rs[1] = rs2;

  // WAW ignores writeback: the RST must actually clear before rd can be reissued.
  assign waw           = rd_we && status[rd].busy;
  assign fu_free       = fu_ready[fu];
  assign unused_status = ^status;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic src_busy;
      assign src_busy = (rs[gi] != '0) && status[rs[gi]].busy;
`ifdef DISPATCH_WB_BYPASS_EN
      assign wait_v[gi] = src_busy && !(wb_write && (wb_sel == rs[gi]));
`else
      assign wait_v[gi] = src_busy;
`endif
      assign tag_v[gi] = (rs[gi] != '0) ? status[rs[gi]].tag : '0;
    end
  endgenerate

`ifndef DISPATCH_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_sel, wb_write};
`endif

  assign rs1_wait = wait_v[0];
  assign rs2_wait = wait_v[1];
  assign rs1_tag  = tag_v[0];
  assign rs2_tag  = tag_v[1];

endmodule

// File: rtl/dispatch_s.sv
// Scalar in-order dispatch: one holding entry, hazard check against the RST,
// one-level branch speculation FSM. Optional macro: DISPATCH_WB_BYPASS_EN.
module dispatch_s
  import datapath_pkg::*;
#(
  parameter int NREGS = DS_NREGS,
  parameter int NFU   = DS_NFU
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NFU)-1:0]   in_fu,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic                     in_rd_we,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic                     in_br,
  input  rst_s_t                   status,
  input  logic [$clog2(NREGS)-1:0] wb_sel,
  input  logic                     wb_write,
  input  logic [NFU-1:0]           fu_ready,
  output logic [NFU-1:0]           fu_valid,
  output logic                     op_rs1_wait,
  output logic                     op_rs2_wait,
  output logic [$clog2(NFU)-1:0]   op_rs1_tag,
  output logic [$clog2(NFU)-1:0]   op_rs2_tag,
  output logic [$clog2(NREGS)-1:0] di_sel,
  output logic                     di_write,
  output logic [$clog2(NFU)-1:0]   di_tag,
  output logic                     spec,
  input  logic                     flush,
  input  logic                     resolved
);

  dispatch_state_t state_reg, state_next;
  dispatch_entry_t entry_reg;

  logic             waw, fu_free, br_block, fire, accept;
  logic             rs1_wait, rs2_wait;
  logic [TAG_W-1:0] rs1_tag, rs2_tag;

  dispatch_hazard u_hazard (
    .fu       (entry_reg.fu),
    .rd       (entry_reg.rd),
    .rd_we    (entry_reg.rd_we),
    .rs1      (entry_reg.rs1),
    .rs2      (entry_reg.rs2),
    .status   (status),
    .fu_ready (fu_ready),
    .wb_sel   (wb_sel),
    .wb_write (wb_write),
    .waw      (waw),
    .fu_free  (fu_free),
    .rs1_wait (rs1_wait),
    .rs2_wait (rs2_wait),
    .rs1_tag  (rs1_tag),
    .rs2_tag  (rs2_tag)
  );

  assign br_block = entry_reg.br && (state_reg == SPEC);
  // A flush kills whatever is held, so it also suppresses fire in that cycle.
  assign fire = entry_reg.valid && fu_free && !waw && !br_block
             && (state_reg != FLUSH) && !flush;
  // Anything offered during the flush cycle is wrong-path; refuse it too.
  assign in_ready = (!entry_reg.valid || fire) && (state_reg != FLUSH) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= NORMAL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      entry_reg <= '0;
    end else if (flush) begin
      entry_reg.valid <= 1'b0;
    end else if (accept) begin
      entry_reg <= '{valid: 1'b1, fu: in_fu, rd: in_rd, rd_we: in_rd_we,
                     rs1: in_rs1, rs2: in_rs2, br: in_br};
    end else if (fire) begin
      entry_reg.valid <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NORMAL: begin
        if (flush)                      state_next = FLUSH;
        else if (fire && entry_reg.br)  state_next = SPEC;
      end
      SPEC: begin
        if (flush)         state_next = FLUSH;
        else if (resolved) state_next = NORMAL;
      end
      FLUSH:   state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_comb begin
    fu_valid    = '0;
    di_write    = 1'b0;
    spec        = 1'b0;
    op_rs1_wait = 1'b0;
    op_rs2_wait = 1'b0;
    if (fire) begin
      fu_valid    = fu_onehot(entry_reg.fu);
      di_write    = entry_reg.rd_we;
      spec        = (state_reg == SPEC);
      op_rs1_wait = rs1_wait;
      op_rs2_wait = rs2_wait;
    end
  end

  assign di_sel     = entry_reg.rd;
  assign di_tag     = entry_reg.fu;
  assign op_rs1_tag = entry_reg.valid ? rs1_tag : '0;
  assign op_rs2_tag = entry_reg.valid ? rs2_tag : '0;

endmodule
